// File: rtl/vga_tile_writer_if.sv
// Request and BMEM write-bus bundle for vga_tile_writer.
//   master : game-logic side; drives req_valid/req_x/req_y/req_data, observes
//            req_ready and the write bus.
//   slave  : the tile writer; consumes requests, drives req_ready and the
//            BMEM write bus (we/waddr/wdata).
interface vga_tile_writer_if #(
  parameter int unsigned DATA_WIDTH = 5
);
  logic                  req_valid;
  logic                  req_ready;
  logic [4:0]            req_x;
  logic [4:0]            req_y;
  logic [DATA_WIDTH-1:0] req_data;
  logic                  we;
  logic [9:0]            waddr;
  logic [DATA_WIDTH-1:0] wdata;

  modport master (
    output req_valid,
    output req_x,
    output req_y,
    output req_data,
    input  req_ready,
    input  we,
    input  waddr,
    input  wdata
  );

  modport slave (
    input  req_valid,
    input  req_x,
    input  req_y,
    input  req_data,
    output req_ready,
    output we,
    output waddr,
    output wdata
  );
endinterface

// File: rtl/vga_tile_writer.sv
// Write-side port of the tile BMEM read by the VGA scan path.
// Cell-update requests (x, y, data) are buffered in a small FIFO and written
// to BMEM address {y, x} one per cycle while write_window is high. A clear
// pulse discards queued requests and sweeps every visible cell with a fill
// value.
// Ports:
//   clk, reset     : clock, asynchronous active-high reset
//   write_window   : BMEM writes permitted (vertical blanking)
//   bus (slave)    : req_valid/req_ready/req_x/req_y/req_data in,
//                    we/waddr/wdata BMEM write bus out
//   clear          : one-cycle pulse, start full-screen clear
//   clear_data     : fill value, sampled with clear
//   busy           : FIFO non-empty or not idle
//   clear_done     : one-cycle pulse the cycle after the last clear write
//   err_oob        : one-cycle pulse when an out-of-range request is dropped
module vga_tile_writer #(
  parameter int unsigned DATA_WIDTH = 5,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned NUM_ROWS   = 24
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  write_window,
  vga_tile_writer_if.slave      bus,
  input  logic                  clear,
  input  logic [DATA_WIDTH-1:0] clear_data,
  output logic                  busy,
  output logic                  clear_done,
  output logic                  err_oob
);

  localparam int unsigned PtrW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned EntryW = 10 + DATA_WIDTH;
  localparam logic [PtrW:0] DepthC    = (PtrW + 1)'(FIFO_DEPTH);
  localparam logic [5:0]    NumRowsC  = 6'(NUM_ROWS);
  localparam logic [9:0]    ClearLast = 10'(NUM_ROWS * 32 - 1);

  typedef enum logic [1:0] {StIdle, StDrain, StClear} state_e;

  state_e state_q, state_d;

  // FIFO storage: entry = {y, x, data}
  logic [EntryW-1:0] mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]     count_q, count_d;

  logic [9:0]            cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] fill_q, fill_d;

  logic                  we_q, we_d;
  logic [9:0]            waddr_q, waddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  clear_last_q, clear_last_d;
  logic                  clear_done_q;
  logic                  err_oob_q;

  logic fifo_full, fifo_empty;
  logic req_ready, accept, req_oob, push, pop, flush;

  logic [EntryW-1:0] head;

  assign fifo_full  = (count_q == DepthC);
  assign fifo_empty = (count_q == '0);

  assign req_ready = ~fifo_full & (state_q != StClear) & ~clear;
  assign accept    = bus.req_valid & req_ready;
  assign req_oob   = ({1'b0, bus.req_y} >= NumRowsC);
  // Out-of-range requests complete the handshake but never reach the FIFO.
  assign push      = accept & ~req_oob;

  assign head = mem_q[rd_ptr_q];

  always_comb begin
    state_d      = state_q;
    pop          = 1'b0;
    flush        = 1'b0;
    cnt_d        = cnt_q;
    fill_d       = fill_q;
    we_d         = 1'b0;
    waddr_d      = waddr_q;
    wdata_d      = wdata_q;
    clear_last_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (clear) begin
          state_d = StClear;
          flush   = 1'b1;
          cnt_d   = '0;
          fill_d  = clear_data;
        end else if (!fifo_empty) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        // A clear preempts draining; pending entries are dropped unwritten.
        if (clear) begin
          state_d = StClear;
          flush   = 1'b1;
          cnt_d   = '0;
          fill_d  = clear_data;
        end else if (fifo_empty) begin
          state_d = StIdle;
        end else if (write_window) begin
          pop     = 1'b1;
          we_d    = 1'b1;
          waddr_d = head[EntryW-1 -: 10];
          wdata_d = head[DATA_WIDTH-1:0];
        end
      end
      StClear: begin
        // clear is ignored here; the sweep only advances with the window.
        if (write_window) begin
          we_d    = 1'b1;
          waddr_d = cnt_q;
          wdata_d = fill_q;
          cnt_d   = cnt_q + 10'd1;
          if (cnt_q == ClearLast) begin
            state_d      = StIdle;
            cnt_d        = '0;
            clear_last_d = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    count_d = count_q;
    if (flush) begin
      count_d = '0;
    end else if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {bus.req_y, bus.req_x, bus.req_data};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      cnt_q        <= '0;
      fill_q       <= '0;
      we_q         <= 1'b0;
      waddr_q      <= '0;
      wdata_q      <= '0;
      clear_last_q <= 1'b0;
      clear_done_q <= 1'b0;
      err_oob_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      cnt_q        <= cnt_d;
      fill_q       <= fill_d;
      we_q         <= we_d;
      waddr_q      <= waddr_d;
      wdata_q      <= wdata_d;
      clear_last_q <= clear_last_d;
      clear_done_q <= clear_last_q;
      err_oob_q    <= accept & req_oob;
      if (flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

  assign bus.req_ready = req_ready;
  assign bus.we        = we_q;
  assign bus.waddr     = waddr_q;
  assign bus.wdata     = wdata_q;
  assign busy          = (state_q != StIdle) | ~fifo_empty;
  assign clear_done    = clear_done_q;
  assign err_oob       = err_oob_q;

endmodule

// File: tb/tb_vga_tile_writer.sv
module tb_vga_tile_writer;
  localparam int DW    = 5;
  localparam int ROWS  = 24;
  localparam int CELLS = ROWS * 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          write_window;
  logic          clear;
  logic [DW-1:0] clear_data;
  logic          busy;
  logic          clear_done;
  logic          err_oob;

  vga_tile_writer_if #(.DATA_WIDTH(DW)) bus ();

  vga_tile_writer #(
    .DATA_WIDTH(DW),
    .FIFO_DEPTH(4),
    .NUM_ROWS  (ROWS)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .write_window(write_window),
    .bus         (bus),
    .clear       (clear),
    .clear_data  (clear_data),
    .busy        (busy),
    .clear_done  (clear_done),
    .err_oob     (err_oob)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int oob_pulses = 0;

  typedef struct {
    int         cyc;
    logic [9:0] addr;
    logic [4:0] data;
  } wr_t;

  typedef struct {
    logic [9:0] addr;
    logic [4:0] data;
  } cell_t;

  wr_t   wr_log[$];
  int    done_log[$];
  cell_t exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.we === 1'b1) wr_log.push_back('{cyc, bus.waddr, bus.wdata});
    if (clear_done === 1'b1) done_log.push_back(cyc);
    if (err_oob === 1'b1) oob_pulses++;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: observed no finish, expected finish before timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Holds the request until accepted; optionally opens the window after a
  // short wait so a full FIFO with a closed window cannot stall forever.
  task automatic push(input logic [4:0] x, input logic [4:0] y, input logic [4:0] d,
                      input bit force_win);
    bit ok;
    bit rdy;
    ok = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_x     = x;
    bus.req_y     = y;
    bus.req_data  = d;
    for (int w = 0; w < 50 && !ok; w++) begin
      @(negedge clk);
      rdy = bus.req_ready;
      tick();
      if (rdy) ok = 1'b1;
      else if (force_win && w >= 2) write_window = 1'b1;
    end
    bus.req_valid = 1'b0;
    chk("push_accepted", 32'(ok), 32'd1);
  endtask

  task automatic pulse_clear(input logic [4:0] fill);
    clear      = 1'b1;
    clear_data = fill;
    @(negedge clk);
    chk("ready_low_on_clear", 32'(bus.req_ready), 32'd0);
    tick();
    clear      = 1'b0;
    clear_data = 5'h00;
  endtask

  initial begin
    int o0;
    int bad;
    int exp_oob;
    int k;
    logic [4:0] rx, ry, rd;
    logic [4:0] fill;

    reset         = 1'b1;
    write_window  = 1'b0;
    clear         = 1'b0;
    clear_data    = '0;
    bus.req_valid = 1'b0;
    bus.req_x     = '0;
    bus.req_y     = '0;
    bus.req_data  = '0;

    // Reset state
    #12;
    chk("rst_we", 32'(bus.we), 32'd0);
    chk("rst_waddr", 32'(bus.waddr), 32'd0);
    chk("rst_wdata", 32'(bus.wdata), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_clear_done", 32'(clear_done), 32'd0);
    chk("rst_err_oob", 32'(err_oob), 32'd0);
    chk("rst_ready", 32'(bus.req_ready), 32'd1);
    tick();
    reset = 1'b0;
    tick();

    // Single write, exact latency
    write_window = 1'b1;
    push(5'd3, 5'd2, 5'd5, 1'b0);
    @(negedge clk);
    chk("single_we_n", 32'(bus.we), 32'd0);
    chk("single_busy_n", 32'(busy), 32'd1);
    @(negedge clk);
    chk("single_we_n1", 32'(bus.we), 32'd0);
    @(negedge clk);
    chk("single_we_n2", 32'(bus.we), 32'd1);
    chk("single_waddr", 32'(bus.waddr), 32'(2 * 32 + 3));
    chk("single_wdata", 32'(bus.wdata), 32'd5);
    chk("single_busy_w", 32'(busy), 32'd1);
    @(negedge clk);
    chk("single_we_off", 32'(bus.we), 32'd0);
    chk("single_busy_off", 32'(busy), 32'd0);
    chk("single_waddr_hold", 32'(bus.waddr), 32'(2 * 32 + 3));
    tick();

    // Fill with window closed: 4 accepted, 5th refused
    write_window = 1'b0;
    exp_q.delete();
    wr_log.delete();
    for (int i = 0; i < 5; i++) begin
      logic rdy;
      rx = 5'($urandom_range(0, 31));
      ry = 5'($urandom_range(0, ROWS - 1));
      rd = 5'($urandom_range(0, 31));
      bus.req_valid = 1'b1;
      bus.req_x = rx;
      bus.req_y = ry;
      bus.req_data = rd;
      @(negedge clk);
      rdy = bus.req_ready;
      chk("fill_ready", 32'(rdy), 32'(exp_q.size() < 4));
      tick();
      if (exp_q.size() < 4) exp_q.push_back('{10'(ry * 32 + rx), rd});
    end
    bus.req_valid = 1'b0;
    repeat (3) tick();
    chk("fill_no_write_closed", 32'(wr_log.size()), 32'd0);
    write_window = 1'b1;
    repeat (8) tick();
    chk("fill_write_count", 32'(wr_log.size()), 32'(exp_q.size()));
    bad = 0;
    for (int i = 0; i < wr_log.size() && i < exp_q.size(); i++) begin
      if (wr_log[i].addr !== exp_q[i].addr || wr_log[i].data !== exp_q[i].data ||
          wr_log[i].cyc != wr_log[0].cyc + i) bad++;
    end
    chk("fill_order_b2b", 32'(bad), 32'd0);

    // Out-of-range request
    wr_log.delete();
    o0 = oob_pulses;
    push(5'd0, 5'd24, 5'd7, 1'b0);
    @(negedge clk);
    chk("oob_pulse", 32'(err_oob), 32'd1);
    @(negedge clk);
    chk("oob_pulse_end", 32'(err_oob), 32'd0);
    chk("oob_fifo_empty", 32'(busy), 32'd0);
    repeat (4) tick();
    chk("oob_count", 32'(oob_pulses - o0), 32'd1);
    chk("oob_no_write", 32'(wr_log.size()), 32'd0);

    // Randomized requests with a random window
    wr_log.delete();
    exp_q.delete();
    o0 = oob_pulses;
    exp_oob = 0;
    for (int i = 0; i < 40; i++) begin
      write_window = 1'($urandom_range(0, 1));
      rx = 5'($urandom_range(0, 31));
      ry = 5'($urandom_range(0, 27));
      rd = 5'($urandom_range(0, 31));
      push(rx, ry, rd, 1'b1);
      if (ry >= ROWS) exp_oob++;
      else exp_q.push_back('{10'(ry * 32 + rx), rd});
      repeat ($urandom_range(0, 2)) begin
        write_window = 1'($urandom_range(0, 1));
        tick();
      end
    end
    write_window = 1'b1;
    for (int w = 0; w < 40 && busy; w++) tick();
    tick();
    chk("rand_drained", 32'(busy), 32'd0);
    chk("rand_write_count", 32'(wr_log.size()), 32'(exp_q.size()));
    bad = 0;
    for (int i = 0; i < wr_log.size() && i < exp_q.size(); i++) begin
      if (wr_log[i].addr !== exp_q[i].addr || wr_log[i].data !== exp_q[i].data) bad++;
    end
    chk("rand_contents", 32'(bad), 32'd0);
    chk("rand_oob_count", 32'(oob_pulses - o0), 32'(exp_oob));

    // Full clear, window held open, re-clear mid-sweep ignored
    wr_log.delete();
    done_log.delete();
    fill = 5'h1F;
    pulse_clear(fill);
    repeat (100) tick();
    chk("clr_busy", 32'(busy), 32'd1);
    pulse_clear(5'h0A);
    k = 0;
    while (k < 2000) begin
      @(negedge clk);
      if (clear_done) break;
      k++;
    end
    chk("clr_done_seen", 32'(k < 2000), 32'd1);
    repeat (4) tick();
    chk("clr_write_count", 32'(wr_log.size()), 32'(CELLS));
    bad = 0;
    for (int i = 0; i < wr_log.size(); i++) begin
      if (wr_log[i].addr !== 10'(i) || wr_log[i].data !== fill ||
          wr_log[i].cyc != wr_log[0].cyc + i) bad++;
    end
    chk("clr_sequence", 32'(bad), 32'd0);
    chk("clr_done_once", 32'(done_log.size()), 32'd1);
    if (done_log.size() > 0 && wr_log.size() > 0)
      chk("clr_done_timing", 32'(done_log[0]), 32'(wr_log[wr_log.size() - 1].cyc + 1));
    chk("clr_idle_after", 32'(busy), 32'd0);

    // Clear with window toggling 100 high / 100 low
    wr_log.delete();
    done_log.delete();
    fill = 5'h15;
    write_window = 1'b1;
    pulse_clear(fill);
    k = 0;
    while (k < 5000) begin
      write_window = ((k / 100) % 2) == 0;
      @(negedge clk);
      if (clear_done) break;
      tick();
      k++;
    end
    chk("tog_done_seen", 32'(k < 5000), 32'd1);
    write_window = 1'b1;
    repeat (4) tick();
    chk("tog_write_count", 32'(wr_log.size()), 32'(CELLS));
    bad = 0;
    for (int i = 0; i < wr_log.size(); i++) begin
      if (wr_log[i].addr !== 10'(i) || wr_log[i].data !== fill) bad++;
    end
    chk("tog_contiguous", 32'(bad), 32'd0);
    chk("tog_done_once", 32'(done_log.size()), 32'd1);

    // Queued entries discarded by clear; reset mid-sweep
    write_window = 1'b0;
    for (int i = 0; i < 3; i++) push(5'(i + 1), 5'd1, 5'd9, 1'b0);
    chk("q3_busy", 32'(busy), 32'd1);
    wr_log.delete();
    fill = 5'h11;
    pulse_clear(fill);
    write_window = 1'b1;
    k = 0;
    while (k < 1000) begin
      @(negedge clk);
      if (bus.we && bus.waddr == 10'd300) break;
      k++;
    end
    chk("rst_mid_reached", 32'(k < 1000), 32'd1);
    #1;
    reset = 1'b1;
    #1;
    chk("rst_mid_we", 32'(bus.we), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_waddr", 32'(bus.waddr), 32'd0);
    repeat (3) tick();
    reset = 1'b0;
    repeat (20) tick();
    chk("rst_mid_write_count", 32'(wr_log.size()), 32'd301);
    bad = 0;
    for (int i = 0; i < wr_log.size(); i++) begin
      if (wr_log[i].addr !== 10'(i) || wr_log[i].data !== fill) bad++;
    end
    chk("rst_mid_only_sweep", 32'(bad), 32'd0);
    chk("rst_mid_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_mid_idle", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
